// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: DIFF = A - B, one bit per clock, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
//
// Handshake: start is a request sampled only while busy=0. The edge that accepts it
// loads the operands and raises busy. Exactly WIDTH edges later done pulses for one
// cycle with diff/bout (and ovf) valid, and busy drops in that same cycle. d_ser is
// qualified by d_ser_valid, which is high for the WIDTH shift cycles only.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             d_ser,
  output logic             d_ser_valid,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             state_dbg
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             borrow;
  logic             load;
  logic             step;
  logic             last;
  logic             hs1_d;
  logic             hs1_b;
  logic             hs2_b;
  logic             d_bit;
  logic             borrow_nxt;

  // Next-state and step control
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Two chained half-subtractors: (a - b), then (that - borrow_in)
  always_comb begin
    hs1_d      = a_sh[0] ^ b_sh[0];
    hs1_b      = ~a_sh[0] & b_sh[0];
    d_bit      = hs1_d ^ borrow;
    hs2_b      = ~hs1_d & borrow;
    borrow_nxt = hs1_b | hs2_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      a_sh        <= '0;
      b_sh        <= '0;
      res_sh      <= '0;
      borrow      <= 1'b0;
      done        <= 1'b0;
      diff        <= '0;
      bout        <= 1'b0;
      d_ser       <= 1'b0;
      d_ser_valid <= 1'b0;
    end else begin
      done        <= last;
      d_ser_valid <= step;
      if (load) begin
        a_sh   <= a;
        b_sh   <= b;
        borrow <= 1'b0;
        cnt    <= '0;
      end else if (step) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        res_sh <= {d_bit, res_sh[WIDTH-1:1]};
        borrow <= borrow_nxt;
        cnt    <= cnt + 1'b1;
        d_ser  <= d_bit;
        // Result registers only move on completion so they hold mid-operation
        if (last) begin
          diff <= {d_bit, res_sh[WIDTH-1:1]};
          bout <= borrow_nxt;
        end
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb;
  logic b_msb;

  // Operand sign bits are shifted out of a_sh/b_sh, so keep them separately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (load) begin
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
      end
      if (last) begin
        ovf <= (a_msb != b_msb) && (d_bit != a_msb);
      end
    end
  end
`endif

  always_comb begin
    busy      = (state == SHIFT);
    state_dbg = state;
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8); OVF checks follow SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;

  localparam int WIDTH  = 8;
  localparam int BUDGET = 4 * WIDTH;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             d_ser;
  logic             d_ser_valid;
  logic             state_dbg;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  int n_vec;
  int n_err;

  logic [WIDTH-1:0] exp_q[$];
  logic             exp_bout_q[$];
  logic             exp_ovf_q[$];

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .diff        (diff),
    .bout        (bout),
    .d_ser       (d_ser),
    .d_ser_valid (d_ser_valid),
`ifdef SERIAL_SUB_OVF_EN
    .ovf         (ovf),
`endif
    .state_dbg   (state_dbg)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard model: plain modular arithmetic
  function automatic void push_exp(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] d;
    d = x - y;
    exp_q.push_back(d);
    exp_bout_q.push_back(x < y);
    exp_ovf_q.push_back((x[WIDTH-1] != y[WIDTH-1]) && (d[WIDTH-1] != x[WIDTH-1]));
  endfunction

  task automatic pop_exp(output logic [WIDTH-1:0] e_d, output logic e_b, output logic e_o);
    if (exp_q.size() == 0) begin
      e_d = 'x;
      e_b = 1'bx;
      e_o = 1'bx;
    end else begin
      e_d = exp_q.pop_front();
      e_b = exp_bout_q.pop_front();
      e_o = exp_ovf_q.pop_front();
    end
  endtask

  // Drivers (called at a falling edge; return at the falling edge after acceptance)
  task automatic start_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    a     = x;
    b     = y;
    start = 1'b1;
    push_exp(x, y);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < BUDGET) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({busy, done, diff, bout, d_ser, d_ser_valid, state_dbg} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: busy=%b done=%b diff=%h bout=%b d_ser=%b vld=%b st=%b, want all 0",
               busy, done, diff, bout, d_ser, d_ser_valid, state_dbg);
    end
`ifdef SERIAL_SUB_OVF_EN
    n_vec++;
    if (ovf !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ovf: got %b want 0", ovf);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    int cycles;
    logic [WIDTH-1:0] e_d;
    logic e_b, e_o;
    start_op(8'd200, 8'd55);
    n_vec++;
    if (state_dbg !== 1'b1) begin
      n_err++;
      $display("FAIL basic_state: got %b want 1", state_dbg);
    end
    cycles = 0;
    while (done !== 1'b1 && cycles < BUDGET) begin
      n_vec++;
      if (busy !== 1'b1) begin
        n_err++;
        $display("FAIL basic_busy: cycle %0d got %b want 1", cycles, busy);
      end
      @(negedge clk);
      cycles++;
    end
    n_vec++;
    if (cycles !== WIDTH) begin
      n_err++;
      $display("FAIL basic_latency: got %0d want %0d", cycles, WIDTH);
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL basic_busy_done: got %b want 0", busy);
    end
    pop_exp(e_d, e_b, e_o);
    n_vec++;
    if (diff !== 8'h91 || bout !== 1'b0 || diff !== e_d || bout !== e_b) begin
      n_err++;
      $display("FAIL basic_result: diff=%h bout=%b want %h %b", diff, bout, e_d, e_b);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL basic_done_pulse: got %b want 0", done);
    end
  endtask

  // Result checks for the borrow and overflow vectors
  task automatic test_borrow_ovf();
    int cycles;
    logic [WIDTH-1:0] e_d;
    logic e_b, e_o;
    logic [WIDTH-1:0] va [2];
    logic [WIDTH-1:0] vb [2];
    va[0] = 8'h05; vb[0] = 8'h09;
    va[1] = 8'h80; vb[1] = 8'h01;
    for (int i = 0; i < 2; i++) begin
      start_op(va[i], vb[i]);
      wait_done(cycles);
      pop_exp(e_d, e_b, e_o);
      n_vec++;
      if (done !== 1'b1 || diff !== e_d || bout !== e_b) begin
        n_err++;
        $display("FAIL borrow_ovf_result[%0d]: done=%b diff=%h bout=%b want 1 %h %b",
                 i, done, diff, bout, e_d, e_b);
      end
`ifdef SERIAL_SUB_OVF_EN
      n_vec++;
      if (ovf !== e_o) begin
        n_err++;
        $display("FAIL ovf[%0d]: got %b want %b", i, ovf, e_o);
      end
`endif
    end
  endtask

  task automatic test_serial_bits();
    int nvalid;
    int cycles;
    logic [WIDTH-1:0] ser_exp;
    logic [WIDTH-1:0] e_d;
    logic e_b, e_o;
    ser_exp = 8'h07;
    nvalid  = 0;
    cycles  = 0;
    start_op(8'h0A, 8'h03);
    n_vec++;
    if (d_ser_valid !== 1'b0) begin
      n_err++;
      $display("FAIL serial_valid_early: got %b want 0", d_ser_valid);
    end
    while (cycles < BUDGET) begin
      if (d_ser_valid === 1'b1) begin
        if (nvalid < WIDTH) begin
          n_vec++;
          if (d_ser !== ser_exp[nvalid]) begin
            n_err++;
            $display("FAIL serial_bit[%0d]: got %b want %b", nvalid, d_ser, ser_exp[nvalid]);
          end
        end
        nvalid++;
      end
      if (done === 1'b1) break;
      @(negedge clk);
      cycles++;
    end
    n_vec++;
    if (nvalid !== WIDTH) begin
      n_err++;
      $display("FAIL serial_valid_count: got %0d want %0d", nvalid, WIDTH);
    end
    pop_exp(e_d, e_b, e_o);
    n_vec++;
    if (done !== 1'b1 || diff !== e_d || bout !== e_b) begin
      n_err++;
      $display("FAIL serial_result: done=%b diff=%h bout=%b want 1 %h %b", done, diff, bout, e_d, e_b);
    end
    @(negedge clk);
    n_vec++;
    if (d_ser_valid !== 1'b0) begin
      n_err++;
      $display("FAIL serial_valid_late: got %b want 0", d_ser_valid);
    end
  endtask

  task automatic test_ignore_start();
    int cycles;
    logic [WIDTH-1:0] e_d;
    logic e_b, e_o;
    logic [WIDTH-1:0] held_diff;
    start_op(8'h33, 8'h11);
    held_diff = diff;
    repeat (2) @(negedge clk);
    a     = 8'hFF;
    b     = 8'h00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if (diff !== held_diff) begin
      n_err++;
      $display("FAIL ignore_diff_hold: got %h want %h", diff, held_diff);
    end
    wait_done(cycles);
    pop_exp(e_d, e_b, e_o);
    n_vec++;
    if (done !== 1'b1 || diff !== e_d || bout !== e_b) begin
      n_err++;
      $display("FAIL ignore_result: done=%b diff=%h bout=%b want 1 %h %b", done, diff, bout, e_d, e_b);
    end
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL ignore_not_queued: busy=%b want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int cycles;
    logic [WIDTH-1:0] e_d;
    logic e_b, e_o;
    a     = 8'h64;
    b     = 8'h20;
    start = 1'b1;
    push_exp(8'h64, 8'h20);
    @(negedge clk);
    a = 8'h10;
    b = 8'h7E;
    push_exp(8'h10, 8'h7E);
    wait_done(cycles);
    pop_exp(e_d, e_b, e_o);
    n_vec++;
    if (cycles !== WIDTH || diff !== e_d || bout !== e_b) begin
      n_err++;
      $display("FAIL b2b_first: cycles=%0d diff=%h bout=%b want %0d %h %b", cycles, diff, bout, WIDTH, e_d, e_b);
    end
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_reaccept: busy=%b want 1", busy);
    end
    wait_done(cycles);
    pop_exp(e_d, e_b, e_o);
    n_vec++;
    if (cycles !== WIDTH || diff !== e_d || bout !== e_b) begin
      n_err++;
      $display("FAIL b2b_second: cycles=%0d diff=%h bout=%b want %0d %h %b", cycles, diff, bout, WIDTH, e_d, e_b);
    end
  endtask

  task automatic test_reset_mid();
    int cycles;
    logic [WIDTH-1:0] e_d;
    logic e_b, e_o;
    start_op(8'h5A, 8'h21);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, done, diff, bout, d_ser, d_ser_valid, state_dbg} !== '0) begin
      n_err++;
      $display("FAIL midreset_outputs: busy=%b done=%b diff=%h bout=%b d_ser=%b vld=%b st=%b, want all 0",
               busy, done, diff, bout, d_ser, d_ser_valid, state_dbg);
    end
`ifdef SERIAL_SUB_OVF_EN
    n_vec++;
    if (ovf !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_ovf: got %b want 0", ovf);
    end
`endif
    exp_q.delete();
    exp_bout_q.delete();
    exp_ovf_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL midreset_quiet[%0d]: done=%b busy=%b want 0 0", i, done, busy);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge clk);
      n_vec++;
      if (done !== 1'b0) begin
        n_err++;
        $display("FAIL midreset_no_done[%0d]: got %b want 0", i, done);
      end
    end
    start_op(8'hFF, 8'hFF);
    wait_done(cycles);
    pop_exp(e_d, e_b, e_o);
    n_vec++;
    if (done !== 1'b1 || diff !== 8'h00 || bout !== 1'b0 || diff !== e_d) begin
      n_err++;
      $display("FAIL midreset_after: done=%b diff=%h bout=%b want 1 00 0", done, diff, bout);
    end
  endtask

  task automatic test_random();
    int cycles;
    logic [WIDTH-1:0] x, y, e_d;
    logic e_b, e_o;
    for (int i = 0; i < 10; i++) begin
      x = WIDTH'($urandom_range(0, 255));
      y = WIDTH'($urandom_range(0, 255));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start_op(x, y);
      wait_done(cycles);
      pop_exp(e_d, e_b, e_o);
      n_vec++;
      if (cycles !== WIDTH || diff !== e_d || bout !== e_b) begin
        n_err++;
        $display("FAIL random[%0d] %h-%h: cycles=%0d diff=%h bout=%b want %0d %h %b",
                 i, x, y, cycles, diff, bout, WIDTH, e_d, e_b);
      end
`ifdef SERIAL_SUB_OVF_EN
      n_vec++;
      if (ovf !== e_o) begin
        n_err++;
        $display("FAIL random_ovf[%0d]: got %b want %b", i, ovf, e_o);
      end
`endif
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_borrow_ovf();
    test_serial_bits();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
